// File: rtl/shiftreg_sched.sv
// Fixed-priority scheduler sharing one parallel-load N-bit shift register among
// four requesters: grant, one load cycle, N shift cycles, then done or abort.
module shiftreg_sched #(
    parameter int N  = 4,
    parameter int CW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [3:0]     req,
    input  logic [4*N-1:0] din,
    output logic [3:0]     gnt,
    output logic [1:0]     code,
    output logic           active,
    output logic           sr_load,
    output logic [N-1:0]   sr_d,
    output logic           sr_shift,
    output logic           busy,
    output logic           done,
    output logic           abort
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE,
        S_ABORT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (req != 4'b0000) begin
                    state_d = S_LOAD;
                    if (req[3])      idx_d = 2'd3;
                    else if (req[2]) idx_d = 2'd2;
                    else if (req[1]) idx_d = 2'd1;
                    else             idx_d = 2'd0;
                end
            end
            S_LOAD: begin
                if (!req[idx_q]) begin
                    state_d = S_ABORT;
                end else begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                // Withdrawal wins even on the final shift cycle.
                if (!req[idx_q])                 state_d = S_ABORT;
                else if (cnt_q == CW'(N - 1))    state_d = S_DONE;
                else                             cnt_d   = cnt_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        active   = |req;
        busy     = (state_q != S_IDLE);
        sr_load  = (state_q == S_LOAD);
        sr_shift = (state_q == S_SHIFT);
        done     = (state_q == S_DONE);
        abort    = (state_q == S_ABORT);
        code     = busy ? idx_q : 2'd0;
        gnt      = 4'b0000;
        if (state_q == S_LOAD || state_q == S_SHIFT || state_q == S_DONE)
            gnt = 4'b0001 << idx_q;
        // The word is taken live from din during the load cycle only.
        sr_d = '0;
        if (state_q == S_LOAD)
            sr_d = din[idx_q*N +: N];
    end

endmodule

// File: tb/tb_shiftreg_sched.sv
// Directed bench for shiftreg_sched: N=4 instance for function/abort/reset
// scenarios, N=8 instance for the longer shift sequence.
module tb_shiftreg_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] din;
    logic [3:0]  gnt;
    logic [1:0]  code;
    logic        active, sr_load, sr_shift, busy, done, abort;
    logic [3:0]  sr_d;

    logic [3:0]  req8;
    logic [31:0] din8;
    logic [3:0]  gnt8;
    logic [1:0]  code8;
    logic        active8, sr_load8, sr_shift8, busy8, done8, abort8;
    logic [7:0]  sr_d8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shiftreg_sched #(.N(4), .CW(4)) dut4 (
        .clk(clk), .reset(reset), .req(req), .din(din),
        .gnt(gnt), .code(code), .active(active), .sr_load(sr_load),
        .sr_d(sr_d), .sr_shift(sr_shift), .busy(busy), .done(done), .abort(abort)
    );

    shiftreg_sched #(.N(8), .CW(4)) dut8 (
        .clk(clk), .reset(reset), .req(req8), .din(din8),
        .gnt(gnt8), .code(code8), .active(active8), .sr_load(sr_load8),
        .sr_d(sr_d8), .sr_shift(sr_shift8), .busy(busy8), .done(done8), .abort(abort8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares the full N=4 output vector {gnt,code,load,shift,busy,done,abort,sr_d}.
    task automatic exp_st(input string tag, input logic [3:0] g, input logic [1:0] c,
                          input logic ld, input logic sh, input logic bz,
                          input logic dn, input logic ab, input logic [3:0] d);
        chk(tag, {17'd0, gnt, code, sr_load, sr_shift, busy, done, abort, sr_d},
                 {17'd0, g, c, ld, sh, bz, dn, ab, d});
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        din   = 16'h9BA5;
        req8  = 4'b0000;
        din8  = 32'h005C_0000;
        step();
        step();
        exp_st("reset_state", 4'b0000, 2'd0, 0, 0, 0, 0, 0, 4'h0);
        chk("reset_state_n8", {gnt8, busy8, sr_load8, sr_shift8}, 32'd0);

        // Single request from requester 1
        reset = 1'b0;
        req   = 4'b0010;
        step();
        exp_st("t1_load", 4'b0010, 2'd1, 1, 0, 1, 0, 0, 4'hA);
        for (int i = 0; i < 4; i++) begin
            step();
            exp_st("t1_shift", 4'b0010, 2'd1, 0, 1, 1, 0, 0, 4'h0);
        end
        step();
        exp_st("t1_done", 4'b0010, 2'd1, 0, 0, 1, 1, 0, 4'h0);
        req = 4'b0000;
        step();
        exp_st("t1_idle", 4'b0000, 2'd0, 0, 0, 0, 0, 0, 4'h0);

        // Priority: 3 beats 1 and 0; lower ones ignored while busy
        req = 4'b1011;
        step();
        exp_st("pri_load", 4'b1000, 2'd3, 1, 0, 1, 0, 0, 4'h9);
        for (int i = 0; i < 4; i++) begin
            step();
            exp_st("pri_shift", 4'b1000, 2'd3, 0, 1, 1, 0, 0, 4'h0);
        end
        step();
        exp_st("pri_done", 4'b1000, 2'd3, 0, 0, 1, 1, 0, 4'h0);
        req = 4'b0011;
        step();
        exp_st("pri_idle", 4'b0000, 2'd0, 0, 0, 0, 0, 0, 4'h0);
        step();
        exp_st("pri_next_load", 4'b0010, 2'd1, 1, 0, 1, 0, 0, 4'hA);
        req = 4'b0000;
        step();
        exp_st("pri_abort_in_load", 4'b0000, 2'd1, 0, 0, 1, 0, 1, 4'h0);
        step();
        exp_st("pri_abort_idle", 4'b0000, 2'd0, 0, 0, 0, 0, 0, 4'h0);

        // Abort: requester 2 withdraws in its 2nd shift cycle
        req = 4'b0100;
        step();
        exp_st("ab_load", 4'b0100, 2'd2, 1, 0, 1, 0, 0, 4'hB);
        step();
        exp_st("ab_shift1", 4'b0100, 2'd2, 0, 1, 1, 0, 0, 4'h0);
        step();
        exp_st("ab_shift2", 4'b0100, 2'd2, 0, 1, 1, 0, 0, 4'h0);
        req = 4'b0000;
        step();
        exp_st("ab_abort", 4'b0000, 2'd2, 0, 0, 1, 0, 1, 4'h0);
        step();
        exp_st("ab_idle", 4'b0000, 2'd0, 0, 0, 0, 0, 0, 4'h0);

        // Reset during the 3rd shift cycle
        req = 4'b0001;
        step();
        exp_st("rs_load", 4'b0001, 2'd0, 1, 0, 1, 0, 0, 4'h5);
        for (int i = 0; i < 3; i++) begin
            step();
            exp_st("rs_shift", 4'b0001, 2'd0, 0, 1, 1, 0, 0, 4'h0);
        end
        reset = 1'b1;
        step();
        exp_st("rs_cleared", 4'b0000, 2'd0, 0, 0, 0, 0, 0, 4'h0);
        reset = 1'b0;
        step();
        exp_st("rs_reload", 4'b0001, 2'd0, 1, 0, 1, 0, 0, 4'h5);
        for (int i = 0; i < 4; i++) begin
            step();
            exp_st("rs_reshift", 4'b0001, 2'd0, 0, 1, 1, 0, 0, 4'h0);
        end
        step();
        exp_st("rs_done", 4'b0001, 2'd0, 0, 0, 1, 1, 0, 4'h0);
        req = 4'b0000;
        step();
        exp_st("rs_idle", 4'b0000, 2'd0, 0, 0, 0, 0, 0, 4'h0);

        // Idle stretch, then back-to-back transfers from requester 0
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_quiet", {busy, gnt, sr_load, sr_shift, active}, 32'd0);
        end
        req = 4'b0001;
        #1;
        chk("active_comb", {31'd0, active}, 32'd1);
        for (int t = 0; t < 2; t++) begin
            step();
            exp_st("b2b_load", 4'b0001, 2'd0, 1, 0, 1, 0, 0, 4'h5);
            for (int i = 0; i < 4; i++) begin
                step();
                exp_st("b2b_shift", 4'b0001, 2'd0, 0, 1, 1, 0, 0, 4'h0);
            end
            step();
            exp_st("b2b_done", 4'b0001, 2'd0, 0, 0, 1, 1, 0, 4'h0);
            if (t == 1) req = 4'b0000;
            step();
            exp_st("b2b_gap_idle", 4'b0000, 2'd0, 0, 0, 0, 0, 0, 4'h0);
        end

        // N=8 instance: 8 shifts, done at cycle 10
        req8 = 4'b0100;
        step();
        chk("n8_load", {gnt8, code8, sr_load8, sr_shift8, sr_d8}, {16'd0, 4'b0100, 2'd2, 1'b1, 1'b0, 8'h5C});
        for (int i = 0; i < 8; i++) begin
            step();
            chk("n8_shift", {gnt8, sr_load8, sr_shift8, done8}, {25'd0, 4'b0100, 1'b0, 1'b1, 1'b0});
        end
        step();
        chk("n8_done", {done8, sr_shift8, busy8, abort8}, {28'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        req8 = 4'b0000;
        step();
        chk("n8_idle", {busy8, done8, gnt8}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
